// File: rtl/dmem_pkg.sv
// Shared address map, RV32 load/store width codes and UART status layout
// for the data-memory / MMIO block.
package dmem_pkg;

    localparam logic [31:0] ADDR_UART_DATA = 32'h1000_0000;
    localparam logic [31:0] ADDR_UART_STAT = 32'h1000_0004;
    localparam logic [31:0] ADDR_LED       = 32'h2000_0000;
    localparam logic [31:0] ADDR_CYC_LO    = 32'h3000_0000;
    localparam logic [31:0] ADDR_CYC_HI    = 32'h3000_0004;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STAT_RX_VALID     = 0;
    localparam int STAT_TX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_TX_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_UART_DATA,
        TGT_UART_STAT,
        TGT_LED,
        TGT_CYC_LO,
        TGT_CYC_HI,
        TGT_NONE
    } target_e;

    // Picks the addressed byte/halfword lane out of a RAM word and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_BU:   load_extend = {24'b0, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_HU:   load_extend = {16'b0, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; power-of-two DEPTH, pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // NOTE: the storage array is deliberately not reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data RAM plus UART/LED MMIO with single-cycle response latency.
// Define DATA_MEM_CYCLE_CNT_EN to add a 64-bit cycle counter at 0x3000_0000/4.
module data_mem_mmio
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS   = 1024,
    parameter int    TXQ_DEPTH     = 8,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [15:0] led_o,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_we,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_re
);
    localparam int          RAM_AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam int          CW        = $clog2(TXQ_DEPTH) + 1;

    target_e     w_target;
    logic        w_fault;
    logic        w_accept;
    logic        w_ok;
    logic        w_ram_en;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;
    logic [31:0] w_mmio_rdata;
    logic [31:0] w_stat;
    logic        w_tx_push_req;
    logic        w_tx_fire;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic [7:0]  w_tx_head;
    logic [CW-1:0] w_tx_count;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_ram_q;
    logic        r_rsp_valid;
    logic        r_rsp_fault;
    logic        r_rsp_from_ram;
    logic [31:0] r_rsp_mmio;
    logic [2:0]  r_rsp_f3;
    logic [1:0]  r_rsp_lane;
    logic [15:0] r_led;
    logic        r_tx_we;
    logic [7:0]  r_tx_data;
`ifdef DATA_MEM_CYCLE_CNT_EN
    logic [63:0] r_cycle;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_target = TGT_NONE;
        if (req_addr < RAM_BYTES) begin
            w_target = TGT_RAM;
        end else begin
            case (req_addr)
                ADDR_UART_DATA: w_target = TGT_UART_DATA;
                ADDR_UART_STAT: w_target = TGT_UART_STAT;
                ADDR_LED:       w_target = TGT_LED;
`ifdef DATA_MEM_CYCLE_CNT_EN
                ADDR_CYC_LO:    w_target = TGT_CYC_LO;
                ADDR_CYC_HI:    w_target = TGT_CYC_HI;
`endif
                default:        w_target = TGT_NONE;
            endcase
        end
    end

    // MMIO registers are word-only; status and counter words are read-only.
    always_comb begin
        w_fault = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) w_fault = 1'b1;
        if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU)) w_fault = 1'b1;
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) w_fault = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00) w_fault = 1'b1;
        if (w_target == TGT_NONE) w_fault = 1'b1;
        if (w_target != TGT_RAM && w_target != TGT_NONE && req_funct3 != F3_W) w_fault = 1'b1;
        if (req_we && (w_target == TGT_UART_STAT || w_target == TGT_CYC_LO || w_target == TGT_CYC_HI))
            w_fault = 1'b1;
    end

    assign w_tx_push_req = req_valid && req_we && (w_target == TGT_UART_DATA) && !w_fault;
    assign req_ready     = !(w_tx_push_req && w_tx_full);
    assign w_accept      = req_valid && req_ready && !rst;
    assign w_ok          = w_accept && !w_fault;
    assign w_ram_en      = w_ok && (w_target == TGT_RAM);
    assign uart_rx_re    = w_ok && !req_we && (w_target == TGT_UART_DATA) && uart_rx_valid;

    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = req_wdata;
        case (req_funct3)
            F3_B: begin
                w_be     = 4'b0001 << req_addr[1:0];
                w_wlanes = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_en) begin
            if (req_we) begin
                for (int i = 0; i < 4; i++)
                    if (w_be[i]) r_mem[req_addr[RAM_AW+1:2]][8*i +: 8] <= w_wlanes[8*i +: 8];
            end else begin
                r_ram_q <= r_mem[req_addr[RAM_AW+1:2]];
            end
        end
    end

    always_comb begin
        w_stat = '0;
        w_stat[STAT_RX_VALID] = uart_rx_valid;
        w_stat[STAT_TX_FULL]  = w_tx_full;
        w_stat[STAT_TX_EMPTY] = w_tx_empty;
        w_stat[STAT_TX_COUNT_LSB +: 8] = 8'(w_tx_count);
    end

    always_comb begin
        w_mmio_rdata = '0;
        case (w_target)
            TGT_UART_DATA: if (uart_rx_valid) w_mmio_rdata = {24'b0, uart_rx_data};
            TGT_UART_STAT: w_mmio_rdata = w_stat;
            TGT_LED:       w_mmio_rdata = {16'b0, r_led};
`ifdef DATA_MEM_CYCLE_CNT_EN
            TGT_CYC_LO:    w_mmio_rdata = r_cycle[31:0];
            TGT_CYC_HI:    w_mmio_rdata = r_cycle[63:32];
`endif
            default:       w_mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_fault    <= 1'b0;
            r_rsp_from_ram <= 1'b0;
            r_rsp_mmio     <= '0;
            r_rsp_f3       <= F3_W;
            r_rsp_lane     <= 2'b00;
            r_led          <= '0;
        end else begin
            r_rsp_valid    <= w_accept;
            r_rsp_fault    <= w_accept && w_fault;
            r_rsp_from_ram <= w_ram_en && !req_we;
            r_rsp_mmio     <= (w_ok && !req_we && w_target != TGT_RAM) ? w_mmio_rdata : '0;
            r_rsp_f3       <= req_funct3;
            r_rsp_lane     <= req_addr[1:0];
            if (w_ok && req_we && w_target == TGT_LED) r_led <= req_wdata[15:0];
        end
    end

    // RAM data arrives from the BRAM output register, so lane extraction happens on the response side.
    assign rsp_valid = r_rsp_valid;
    assign rsp_fault = r_rsp_fault;
    assign rsp_rdata = (!r_rsp_valid || r_rsp_fault) ? 32'b0 :
                       r_rsp_from_ram ? load_extend(r_ram_q, r_rsp_f3, r_rsp_lane) : r_rsp_mmio;
    assign led_o     = r_led;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(TXQ_DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_tx_push_req && w_accept),
        .i_data (req_wdata[7:0]),
        .i_pop  (w_tx_fire),
        .o_data (w_tx_head),
        .o_empty(w_tx_empty),
        .o_full (w_tx_full),
        .o_count(w_tx_count)
    );

    // A strobe in the current cycle blocks the next one, giving the transmitter a cycle to raise busy.
    assign w_tx_fire = !w_tx_empty && !uart_tx_busy && !r_tx_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_we   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_we <= w_tx_fire;
            if (w_tx_fire) r_tx_data <= w_tx_head;
        end
    end

    assign uart_tx_we   = r_tx_we;
    assign uart_tx_data = r_tx_data;

`ifdef DATA_MEM_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cycle <= '0;
        else     r_cycle <= r_cycle + 64'd1;
    end
`endif

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios plus randomized
// RAM/MMIO traffic checked against a byte-array reference model.
module tb_data_mem_mmio;

    localparam int DEPTH_WORDS = 1024;
    localparam int TXQ         = 8;
    localparam logic [31:0] A_UDATA = 32'h1000_0000;
    localparam logic [31:0] A_USTAT = 32'h1000_0004;
    localparam logic [31:0] A_LED   = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [15:0] led_o;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_we;
    logic        uart_tx_busy = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_re;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    data_mem_mmio #(
        .DEPTH_WORDS  (DEPTH_WORDS),
        .TXQ_DEPTH    (TXQ),
        .MEM_INIT_FILE("")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_funct3   (req_funct3),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .led_o        (led_o),
        .uart_tx_data (uart_tx_data),
        .uart_tx_we   (uart_tx_we),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_re   (uart_rx_re)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // TX monitor: collects strobed bytes, flags back-to-back strobes and data changing between strobes.
    logic [7:0] tx_seen[$];
    int         consec_err = 0;
    int         hold_err   = 0;
    logic       prev_we    = 1'b0;
    logic [7:0] last_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_we   = 1'b0;
            last_data = '0;
        end else begin
            if (uart_tx_we) begin
                if (prev_we) consec_err++;
                tx_seen.push_back(uart_tx_data);
                last_data = uart_tx_data;
            end else if (uart_tx_data !== last_data) begin
                hold_err++;
            end
            prev_we = uart_tx_we;
        end
    end

    // Reference model: byte-addressed RAM, LED register and TX queue occupancy.
    logic [7:0]  m_mem [DEPTH_WORDS*4];
    logic [15:0] m_led = '0;
    logic [7:0]  m_txq[$];

    function automatic void model_access(input logic we, input logic [31:0] a, input logic [2:0] f3,
                                         input logic [31:0] wd, input logic rxv, input logic [7:0] rxd,
                                         output logic [31:0] rd, output logic flt, output logic rxre);
        int size;
        bit is_ram;
        bit is_mmio;
        logic [31:0] v;
        rd = '0; flt = 1'b0; rxre = 1'b0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        is_ram  = (a < DEPTH_WORDS*4);
        is_mmio = (a == A_UDATA) || (a == A_USTAT) || (a == A_LED);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) flt = 1'b1;
        if (we && f3[2]) flt = 1'b1;
        if ((a % size) != 0) flt = 1'b1;
        if (!is_ram && !is_mmio) flt = 1'b1;
        if (is_mmio && f3 != 3'd2) flt = 1'b1;
        if (is_mmio && we && a == A_USTAT) flt = 1'b1;
        if (flt) return;
        if (is_ram) begin
            if (we) begin
                for (int k = 0; k < size; k++) m_mem[a+k] = wd[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < size; k++) v[8*k +: 8] = m_mem[a+k];
                if (!f3[2] && size < 4 && v[8*size-1])
                    for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
                rd = v;
            end
        end else if (a == A_LED) begin
            if (we) m_led = wd[15:0];
            else    rd = {16'h0, m_led};
        end else if (a == A_UDATA) begin
            if (we) m_txq.push_back(wd[7:0]);
            else if (rxv) begin
                rd = {24'h0, rxd};
                rxre = 1'b1;
            end
        end else begin
            rd = {16'h0, 8'(m_txq.size()), 5'b0, m_txq.size() == 0, m_txq.size() == TXQ, rxv};
        end
    endfunction

    // Issues one request starting at a falling edge; returns at the falling edge that shows the response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                          input int budget, output logic ok, output logic rv, output logic [31:0] rd,
                          output logic flt, output logic re_acc, output logic re_after, output int acc_cyc);
        int n;
        req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
        n = 0; ok = 0; rv = 0; rd = '0; flt = 0; re_acc = 0; re_after = 0; acc_cyc = 0;
        #1;
        while (!req_ready && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            @(negedge clk);
            return;
        end
        ok = 1'b1; re_acc = uart_rx_re; acc_cyc = cyc_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        rv = rsp_valid; rd = rsp_rdata; flt = rsp_fault; re_after = uart_rx_re;
    endtask

    logic ok, rv, flt, re_a, re_b;
    logic [31:0] rd;
    int acc;

    task automatic test_reset;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        total++; if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault got=%b exp=0", rsp_fault); end
        total++; if (led_o !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=0", led_o); end
        total++; if (uart_tx_we !== 1'b0 || uart_tx_data !== 8'h0)
            begin bad++; $display("FAIL reset_tx got we=%b data=%h exp 0/00", uart_tx_we, uart_tx_data); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_ram_directed;
        do_req(1, 32'h10, 3'b010, 32'hDEADBEEF, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (!ok || rv !== 1'b1 || flt !== 1'b0)
            begin bad++; $display("FAIL sw_resp got ok=%b v=%b f=%b exp 1/1/0", ok, rv, flt); end
        do_req(0, 32'h13, 3'b000, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'hFFFFFFDE || flt !== 1'b0 || rv !== 1'b1)
            begin bad++; $display("FAIL lb_after_sw got=%h f=%b exp=ffffffde f=0", rd, flt); end
        do_req(0, 32'h10, 3'b101, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h0000BEEF || flt !== 1'b0)
            begin bad++; $display("FAIL lhu got=%h f=%b exp=0000beef f=0", rd, flt); end
        total++; @(negedge clk); if (rsp_valid !== 1'b0)
            begin bad++; $display("FAIL rsp_one_cycle got=%b exp=0", rsp_valid); end
        do_req(0, 32'h6, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (flt !== 1'b1 || rd !== 32'h0 || rv !== 1'b1)
            begin bad++; $display("FAIL lw_misaligned got f=%b rd=%h exp f=1 rd=0", flt, rd); end
        do_req(1, 32'h0, 3'b010, 32'h11223344, 2, ok, rv, rd, flt, re_a, re_b, acc);
        do_req(1, 32'h3, 3'b001, 32'hFFFF5566, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (flt !== 1'b1) begin bad++; $display("FAIL sh_misaligned got f=%b exp=1", flt); end
        do_req(0, 32'h0, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL sh_no_effect got=%h exp=11223344", rd); end
        do_req(0, 32'h4000_0000, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (flt !== 1'b1 || rd !== 32'h0)
            begin bad++; $display("FAIL unmapped got f=%b rd=%h exp f=1 rd=0", flt, rd); end
        do_req(1, DEPTH_WORDS*4-4, 3'b010, 32'hA5A55A5A, 2, ok, rv, rd, flt, re_a, re_b, acc);
        do_req(0, DEPTH_WORDS*4-4, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'hA5A55A5A || flt !== 1'b0)
            begin bad++; $display("FAIL ram_top_word got=%h f=%b exp=a5a55a5a", rd, flt); end
        do_req(0, DEPTH_WORDS*4, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (flt !== 1'b1) begin bad++; $display("FAIL ram_past_end got f=%b exp=1", flt); end
    endtask

    task automatic test_random;
        logic        we, rxv, e_flt, e_re;
        logic [31:0] a, wd, e_rd;
        logic [2:0]  f3;
        logic [7:0]  rxd;
        logic [2:0]  st_f3 [3];
        logic [31:0] bad_a [5];
        int          sel;
        st_f3 = '{3'b000, 3'b001, 3'b010};
        bad_a = '{32'h4000_0000, 32'(DEPTH_WORDS*4), 32'h1000_0008, 32'h2000_0004, 32'hFFFF_FFFC};
        for (int w = 0; w < 16; w++) begin
            wd = $urandom();
            model_access(1, 32'(w*4), 3'b010, wd, 0, 0, e_rd, e_flt, e_re);
            do_req(1, 32'(w*4), 3'b010, wd, 2, ok, rv, rd, flt, re_a, re_b, acc);
        end
        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1)); wd = $urandom();
            rxv = 1'($urandom_range(0, 1)); rxd = 8'($urandom());
            a = 32'($urandom_range(0, 63)); f3 = 3'($urandom_range(0, 7));
            if (sel <= 5) begin
                if (we) f3 = st_f3[$urandom_range(0, 2)];
            end else if (sel == 6) begin
                a = A_LED; f3 = ($urandom_range(0, 3) == 0 && we) ? 3'b000 : 3'b010;
            end else if (sel == 7) begin
                a = A_USTAT; we = 0; f3 = 3'b010;
            end else if (sel == 8) begin
                a = A_UDATA; we = 0; f3 = 3'b010;
            end else begin
                a = bad_a[$urandom_range(0, 4)]; f3 = 3'b010;
            end
            uart_rx_valid = rxv; uart_rx_data = rxd;
            model_access(we, a, f3, wd, rxv, rxd, e_rd, e_flt, e_re);
            do_req(we, a, f3, wd, 2, ok, rv, rd, flt, re_a, re_b, acc);
            total++;
            if (!ok || rv !== 1'b1 || flt !== e_flt || re_a !== e_re || re_b !== 1'b0 ||
                ((!we || e_flt) && rd !== e_rd)) begin
                bad++;
                $display("FAIL rand[%0d] we=%b a=%h f3=%0d got ok=%b v=%b f=%b rd=%h re=%b/%b exp f=%b rd=%h re=%b",
                         t, we, a, f3, ok, rv, flt, rd, re_a, re_b, e_flt, e_rd, e_re);
            end
        end
        uart_rx_valid = 1'b0;
        for (int w = 0; w < 16; w++) begin
            model_access(0, 32'(w*4), 3'b010, 0, 0, 0, e_rd, e_flt, e_re);
            do_req(0, 32'(w*4), 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
            total++; if (rd !== e_rd) begin bad++; $display("FAIL rand_sweep[%0d] got=%h exp=%h", w, rd, e_rd); end
        end
        total++; if (led_o !== m_led) begin bad++; $display("FAIL rand_led got=%h exp=%h", led_o, m_led); end
    endtask

    task automatic test_uart_rx;
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        do_req(0, A_UDATA, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h5A || re_a !== 1'b1 || re_b !== 1'b0)
            begin bad++; $display("FAIL rx_valid got rd=%h re=%b/%b exp rd=5a re=1/0", rd, re_a, re_b); end
        uart_rx_valid = 1'b0;
        do_req(0, A_UDATA, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h0 || re_a !== 1'b0 || flt !== 1'b0)
            begin bad++; $display("FAIL rx_empty got rd=%h re=%b f=%b exp 0/0/0", rd, re_a, flt); end
    endtask

    task automatic test_uart_tx;
        logic [7:0]  exp_b [9];
        logic [7:0]  got;
        logic [31:0] wd;
        int          n;
        tx_seen.delete(); consec_err = 0; hold_err = 0;
        uart_tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) exp_b[i] = 8'($urandom());
        for (int i = 0; i < 8; i++) begin
            wd = $urandom(); wd[7:0] = exp_b[i];
            do_req(1, A_UDATA, 3'b010, wd, 2, ok, rv, rd, flt, re_a, re_b, acc);
            total++; if (!ok || flt !== 1'b0) begin bad++; $display("FAIL tx_push[%0d] got ok=%b f=%b", i, ok, flt); end
        end
        req_we = 1; req_addr = A_UDATA; req_funct3 = 3'b010; req_wdata = {24'h0, exp_b[8]}; req_valid = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL tx_full_stall[%0d] got=%b exp=0", c, req_ready); end
            @(negedge clk);
        end
        req_valid = 0;
        do_req(0, A_USTAT, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h0000_0802) begin bad++; $display("FAIL stat_full got=%h exp=00000802", rd); end
        total++; if (tx_seen.size() != 0) begin bad++; $display("FAIL tx_busy_hold got=%0d exp=0", tx_seen.size()); end
        uart_tx_busy = 1'b0;
        do_req(1, A_UDATA, 3'b010, {24'h0, exp_b[8]}, 20, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (!ok) begin bad++; $display("FAIL tx_ninth_accept got=0 exp=1"); end
        n = 0;
        while (tx_seen.size() < 9 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        total++; if (tx_seen.size() != 9) begin bad++; $display("FAIL tx_count got=%0d exp=9", tx_seen.size()); end
        for (int i = 0; i < 9; i++) begin
            got = (i < tx_seen.size()) ? tx_seen[i] : 8'hxx;
            total++; if (got !== exp_b[i]) begin bad++; $display("FAIL tx_byte[%0d] got=%h exp=%h", i, got, exp_b[i]); end
        end
        total++; if (consec_err != 0 || hold_err != 0)
            begin bad++; $display("FAIL tx_strobe got consec=%0d hold=%0d exp 0/0", consec_err, hold_err); end
        do_req(0, A_USTAT, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h0000_0004) begin bad++; $display("FAIL stat_empty got=%h exp=00000004", rd); end
    endtask

    task automatic test_led_reset;
        int n;
        int cnt0;
        do_req(1, A_LED, 3'b010, 32'hABCD1234, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (led_o !== 16'h1234) begin bad++; $display("FAIL led_write got=%h exp=1234", led_o); end
        do_req(0, A_LED, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL led_read got=%h exp=00001234", rd); end
        do_req(1, 32'h100, 3'b010, 32'hCAFEF00D, 2, ok, rv, rd, flt, re_a, re_b, acc);
        uart_tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) do_req(1, A_UDATA, 3'b010, 32'(i + 1), 2, ok, rv, rd, flt, re_a, re_b, acc);
        uart_tx_busy = 1'b0;
        n = 0;
        while (uart_tx_we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++; if (uart_tx_we !== 1'b1) begin bad++; $display("FAIL drain_start got we=%b exp=1", uart_tx_we); end
        #1 rst = 1'b1;
        #1;
        total++; if (led_o !== 16'h0 || uart_tx_we !== 1'b0 || uart_tx_data !== 8'h0 || rsp_valid !== 1'b0)
            begin bad++; $display("FAIL async_reset got led=%h we=%b data=%h v=%b exp all 0", led_o, uart_tx_we, uart_tx_data, rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        cnt0 = tx_seen.size();
        repeat (20) @(negedge clk);
        total++; if (tx_seen.size() != cnt0) begin bad++; $display("FAIL fifo_flushed got=%0d exp=%0d", tx_seen.size(), cnt0); end
        do_req(0, A_USTAT, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h0000_0004) begin bad++; $display("FAIL stat_after_reset got=%h exp=00000004", rd); end
        do_req(0, 32'h100, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL ram_retained got=%h exp=cafef00d", rd); end
        req_we = 0; req_addr = 32'h100; req_funct3 = 3'b010; req_valid = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_discard got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_cycle_cnt;
`ifdef DATA_MEM_CYCLE_CNT_EN
        logic [31:0] r1;
        int          a1;
        do_req(0, 32'h3000_0000, 3'b010, 0, 2, ok, rv, r1, flt, re_a, re_b, a1);
        repeat ($urandom_range(3, 20)) @(negedge clk);
        do_req(0, 32'h3000_0000, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd - r1 !== 32'(acc - a1) || flt !== 1'b0)
            begin bad++; $display("FAIL cyc_delta got=%0d exp=%0d", rd - r1, acc - a1); end
        do_req(0, 32'h3000_0004, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (rd !== 32'h0 || flt !== 1'b0) begin bad++; $display("FAIL cyc_hi got=%h f=%b exp=0", rd, flt); end
        do_req(1, 32'h3000_0000, 3'b010, 32'h5, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (flt !== 1'b1) begin bad++; $display("FAIL cyc_store got f=%b exp=1", flt); end
`else
        do_req(0, 32'h3000_0000, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (flt !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL cyc_lo_unmapped got f=%b rd=%h", flt, rd); end
        do_req(0, 32'h3000_0004, 3'b010, 0, 2, ok, rv, rd, flt, re_a, re_b, acc);
        total++; if (flt !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL cyc_hi_unmapped got f=%b rd=%h", flt, rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_ram_directed();
        test_random();
        test_uart_rx();
        test_uart_tx();
        test_led_reset();
        test_cycle_cnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
